// File: rtl/dnn_pkg.sv
// Shared types and constants for the fixed-point dot-product unit.
// Saturating arithmetic is selected with the DNN_DOT_SAT_EN macro.
package dnn_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 16;

    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_FINAL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dnn_fxp_mul.sv
// Registered signed fixed-point multiply with narrowing to DATA_W.
// DNN_DOT_SAT_EN selects saturating narrowing; otherwise it wraps.
module dnn_fxp_mul
    import dnn_pkg::*;
#(
    parameter int DATA_W    = dnn_pkg::DATA_W,
    parameter int FRAC_BITS = dnn_pkg::FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_p
);

    logic signed [2*DATA_W-1:0] w_full;
    logic        [DATA_W-1:0]   w_nar;
    logic                       r_valid;
    logic        [DATA_W-1:0]   r_p;

    assign w_full =
        $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
        $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});

`ifdef DNN_DOT_SAT_EN
    localparam logic [DATA_W-1:0] L_MAX =
        {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] L_MIN =
        {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] w_shift;
    logic        [DATA_W:0]     w_top;

    assign w_shift = w_full >>> FRAC_BITS;
    // Bits above the result sign must all match it to fit.
    assign w_top   = w_shift[2*DATA_W-1:DATA_W-1];
    assign w_nar   = (&w_top || ~|w_top) ? w_shift[DATA_W-1:0]
                   : (w_top[DATA_W] ? L_MIN : L_MAX);
`else
    assign w_nar = DATA_W'(w_full >>> FRAC_BITS);
`endif

    // Product register; valid tracks one beat through the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_p     <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) r_p <= w_nar;
        end
    end

    assign o_valid = r_valid;
    assign o_p     = r_p;

endmodule

// File: rtl/dnn_dot_unit.sv
// Fixed-point dot product with bias and optional ReLU.
// DNN_DOT_SAT_EN turns on saturating adds and product narrowing.
module dnn_dot_unit
    import dnn_pkg::*;
#(
    parameter int DATA_W    = dnn_pkg::DATA_W,
    parameter int FRAC_BITS = dnn_pkg::FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       len,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_weight,
    input  logic [DATA_W-1:0] in_activ,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

`ifdef DNN_DOT_SAT_EN
    localparam logic [DATA_W-1:0] L_MAX =
        {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] L_MIN =
        {1'b1, {(DATA_W-1){1'b0}}};
`endif

    function automatic logic [DATA_W-1:0] f_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
`ifdef DNN_DOT_SAT_EN
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1])
            f_add = s[DATA_W] ? L_MIN : L_MAX;
        else
            f_add = s[DATA_W-1:0];
`else
        f_add = a + b;
`endif
    endfunction

    state_t            r_state, w_next;
    logic [31:0]       r_len, r_cnt;
    logic [DATA_W-1:0] r_bias, r_acc, r_out;
    logic              r_relu;
    logic              w_start, w_beat, w_pvalid;
    logic [DATA_W-1:0] w_prod, w_sum;

    assign w_start  = start && (r_state == ST_IDLE);
    assign in_ready = (r_state == ST_ACCUM) && (r_cnt < r_len);
    assign w_beat   = in_valid && in_ready;
    assign w_sum    = f_add(r_acc, r_bias);

    dnn_fxp_mul #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_beat),
        .i_a     (in_weight),
        .i_b     (in_activ),
        .o_valid (w_pvalid),
        .o_p     (w_prod)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state; DRAIN waits for the product stage to empty.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:
                if (start)
                    w_next = (len != 32'd0) ? ST_ACCUM : ST_FINAL;
            ST_ACCUM:
                if (w_beat && (r_cnt + 32'd1 == r_len))
                    w_next = ST_DRAIN;
            ST_DRAIN:
                if (!w_pvalid) w_next = ST_FINAL;
            ST_FINAL:
                w_next = ST_DONE;
            ST_DONE:
                if (out_ready) w_next = ST_IDLE;
            default:
                w_next = ST_IDLE;
        endcase
    end

    // Operation parameters, captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len  <= '0;
            r_bias <= '0;
            r_relu <= 1'b0;
        end else if (w_start) begin
            r_len  <= len;
            r_bias <= bias;
            r_relu <= relu_en;
        end
    end

    // Beat counter and accumulator fed by the product stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else begin
            if (w_beat)   r_cnt <= r_cnt + 32'd1;
            if (w_pvalid) r_acc <= f_add(r_acc, w_prod);
        end
    end

    // Result register; holds its value through DONE.
    always_ff @(posedge clk) begin
        if (rst)
            r_out <= '0;
        else if (r_state == ST_FINAL)
            r_out <= (r_relu && w_sum[DATA_W-1]) ? '0 : w_sum;
    end

    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_out;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dnn_dot_unit.sv
// Randomized bench for dnn_dot_unit against a behavioural model.
// Model follows DNN_DOT_SAT_EN the same way the design build does.
module tb_dnn_dot_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] len;
    logic [31:0] bias;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_weight;
    logic [31:0] in_activ;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int n_hs   = 0;

    logic [31:0] q_w[$];
    logic [31:0] q_a[$];

    always #5 clk = ~clk;

    dnn_dot_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_activ  (in_activ),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Completed result handshakes.
    always @(posedge clk)
        if (!rst && out_valid && out_ready) n_hs++;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Fit a wide value into 32 bits: clamp or wrap.
    function automatic longint m_fit(input longint v);
`ifdef DNN_DOT_SAT_EN
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
`else
        return longint'($signed(v[31:0]));
`endif
    endfunction

    function automatic logic [31:0] m_expect(input logic [31:0] b,
                                             input logic r);
        longint acc = 0;
        longint p;
        longint res;
        for (int i = 0; i < q_w.size(); i++) begin
            p = longint'($signed(q_w[i])) *
                longint'($signed(q_a[i]));
            p = p >>> 16;
            acc = m_fit(acc + m_fit(p));
        end
        res = m_fit(acc + longint'($signed(b)));
        if (r && res < 0) res = 0;
        return res[31:0];
    endfunction

    task automatic run_op(input string tag, input int n,
                          input logic [31:0] b, input logic r,
                          input bit gaps, input int hold,
                          input bit noise,
                          output logic [31:0] got);
        logic [31:0] exp;
        int lat;
        int t;
        exp = m_expect(b, r);
        got = 'x;
        @(negedge clk);
        start = 1'b1; len = n; bias = b; relu_en = r;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            in_valid  = 1'b1;
            in_weight = q_w[i];
            in_activ  = q_a[i];
            if (noise) begin
                start = 1'b1; len = 32'd7;
                bias = $urandom; relu_en = ~r;
                out_ready = 1'b1;
            end
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t == 50) begin
                chk({tag, "_rdy_to"}, 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        if (n > 0)
            chk({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, (n == 0) ? 1 : 3);
        if (!out_valid) return;
        got = out_data;
        chk({tag, "_data"}, out_data, exp);
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_d"}, out_data, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    logic [31:0] got;
    int exp_hs;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; bias = '0;
        relu_en = 1'b0; in_valid = 1'b0; in_weight = '0;
        in_activ = '0; out_ready = 1'b0;
        exp_hs = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags",
            {29'd0, in_ready, out_valid, busy}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        rst = 1'b0;

        q_w = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
        q_a = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        run_op("d3", 3, 32'h0000_8000, 1'b0, 0, 0, 0, got);
        chk("d3_const", got, 32'h0006_8000);
        exp_hs++;

        run_op("bp", 3, 32'h0000_8000, 1'b0, 1, 5, 1, got);
        chk("bp_const", got, 32'h0006_8000);
        exp_hs++;

        q_w = '{32'hFFFE_0000};
        q_a = '{32'h0001_0000};
        run_op("relu1", 1, 32'h0, 1'b1, 0, 1, 0, got);
        chk("relu1_const", got, 32'h0000_0000);
        run_op("relu0", 1, 32'h0, 1'b0, 0, 1, 0, got);
        chk("relu0_const", got, 32'hFFFE_0000);
        exp_hs += 2;

        q_w.delete();
        q_a.delete();
        run_op("len0", 0, 32'hFFFF_0000, 1'b1, 0, 2, 0, got);
        chk("len0_const", got, 32'h0);
        exp_hs++;

        q_w = '{32'h7FFF_0000};
        q_a = '{32'h7FFF_0000};
        run_op("big", 1, 32'h0, 1'b0, 0, 0, 0, got);
`ifdef DNN_DOT_SAT_EN
        chk("big_const", got, 32'h7FFF_FFFF);
`else
        chk("big_const", got, 32'h0001_0000);
`endif
        exp_hs++;

        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(0, 6);
            q_w.delete();
            q_a.delete();
            for (int i = 0; i < n; i++) begin
                if (k[0]) begin
                    q_w.push_back($urandom);
                    q_a.push_back($urandom);
                end else begin
                    q_w.push_back(32'($urandom_range(0, 32'h8_0000))
                                  - 32'h4_0000);
                    q_a.push_back(32'($urandom_range(0, 32'h8_0000))
                                  - 32'h4_0000);
                end
            end
            run_op($sformatf("rnd%0d", k), n, $urandom,
                   1'($urandom_range(0, 1)), k[1],
                   $urandom_range(0, 3), k[2], got);
            exp_hs++;
        end

        q_w = '{32'h0001_0000, 32'h0002_0000,
                32'h0003_0000, 32'h0004_0000};
        q_a = '{32'h0001_0000, 32'h0001_0000,
                32'h0001_0000, 32'h0001_0000};
        @(negedge clk);
        start = 1'b1; len = 32'd4; bias = 32'h0;
        relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_weight = q_w[i];
            in_activ = q_a[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_flags",
            {29'd0, in_ready, out_valid, busy}, 32'd0);
        chk("abort_data", out_data, 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_quiet", 32'(out_valid), 32'd0);
        end
        q_w = '{32'h0001_0000};
        q_a = '{32'h0001_0000};
        run_op("post", 1, 32'h0, 1'b0, 0, 1, 0, got);
        chk("post_const", got, 32'h0001_0000);
        exp_hs++;

        repeat (4) @(negedge clk);
        chk("hs_count", n_hs, exp_hs);

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dnn_dot_unit.md
DNN_DOT_UNIT -- requirements
Module: dnn_dot_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter FRAC_BITS, default 16, fractional bits of signed fixed-point format (Q16.16).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse launching a dot product; ignored unless IDLE.
REQ-007 len  in  32  beat count, sampled on accepted start.
REQ-008 bias  in  DATA_W  bias word, sampled on accepted start.
REQ-009 relu_en  in  1  apply ReLU to result, sampled on accepted start.
REQ-010 in_valid / in_ready  in / out  1  operand-beat handshake.
REQ-011 in_weight, in_activ  in  DATA_W  signed operand pair.
REQ-012 out_valid / out_ready  out / in  1  result handshake.
REQ-013 out_data  out  DATA_W  signed result.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, ACCUM, DRAIN, FINAL, DONE.
REQ-016 IDLE: start=1 with len>0 -> ACCUM; start=1 with len=0 -> FINAL; accumulator cleared on start.
REQ-017 ACCUM: in_ready=1 while accepted-beat count < len; a beat transfers on in_valid&&in_ready.
REQ-018 The product SHALL be (weight*activ) computed at 2*DATA_W bits, arithmetic-shifted right by FRAC_BITS, then narrowed to DATA_W and registered.
REQ-019 The registered product SHALL be added to the accumulator on the following edge.
REQ-020 After the len-th beat is accepted: ACCUM -> DRAIN; in_ready=0 from the next cycle.
REQ-021 DRAIN -> FINAL once the product pipeline is empty.
REQ-022 FINAL SHALL compute acc+bias, clamp negatives to 0 if relu_en, register into out_data, and go to DONE.
REQ-023 DONE: out_valid=1, out_data stable until out_ready=1; then -> IDLE.
REQ-024 out_valid SHALL rise on the 3rd rising edge after the edge accepting the last beat; for len=0, on the 2nd edge after start.
REQ-025 Gaps in in_valid SHALL stall without loss; back-to-back beats SHALL sustain one beat per cycle.
REQ-026 start while busy=1 SHALL be ignored, with no change to the sampled len, bias or relu_en.
REQ-027 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-028 On rst: state IDLE; in_ready=0, out_valid=0, busy=0, out_data=0; accumulator, beat counter and pipeline cleared.
REQ-029 rst mid-operation SHALL abort and discard the partial result; no out_valid is produced for that operation.

Configuration
REQ-030 With DNN_DOT_SAT_EN defined, product narrowing, accumulator add and bias add SHALL saturate to 0x7FFFFFFF / 0x80000000.
REQ-031 Without DNN_DOT_SAT_EN, these operations SHALL wrap modulo 2^DATA_W (truncation).

Structure
REQ-032 Package dnn_pkg SHALL hold the state enum, DATA_W, FRAC_BITS, and the SAT_MAX / SAT_MIN constants.
REQ-033 Sub-module dnn_fxp_mul SHALL implement the registered signed fixed-point multiply, including the narrowing step (saturating or wrapping).

Verification
REQ-034 len=3, w={0x00010000,0x00020000,0x00030000}, a=0x00010000 each, bias=0x00008000, relu_en=0 -> out_data=0x00068000, 3 edges after the last beat.
REQ-035 len=1, w=0xFFFE0000, a=0x00010000, bias=0: relu_en=1 -> 0x00000000; relu_en=0 -> 0xFFFE0000.
REQ-036 len=0, bias=0xFFFF0000, relu_en=1 -> out_valid on the 2nd edge after start, out_data=0.
REQ-037 w=a=0x7FFF0000, len=1: with DNN_DOT_SAT_EN -> 0x7FFFFFFF; without -> 0x00010000.
REQ-038 Backpressure: random in_valid gaps and out_ready held low 5 cycles -> result matches REQ-034; out_data stable while out_valid=1 and out_ready=0.
REQ-039 rst asserted after 2 of 4 beats, then a new start with len=1, w=a=0x00010000, bias=0 -> single output 0x00010000; no stale result appears.
